syn_md_acq_sched: RTL and testbench

SYN_MD_ACQ_SCHED -- requirements
Module: syn_md_acq_sched

---
 rtl/syn_md_pkg.sv | 28 ++
 rtl/syn_md_rise_sync.sv | 37 +++
 rtl/syn_md_acq_sched.sv | 218 +++++++++++++++++++++
 tb/tb_syn_md_acq_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/syn_md_pkg.sv
// -----------------------------------------------------------------------------
// syn_md_pkg
// Shared definitions for the sync-driven acquisition scheduler:
//   - default widths for the delay/window counters and the shot counter
//   - default sync-wait timeout length (used only with SYN_MD_TIMEOUT_EN)
//   - scheduler state encoding
//   - helper classifying states in which a sync edge is ignored
// -----------------------------------------------------------------------------
package syn_md_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int SHOT_W_DEF      = 8;
  localparam int TIMEOUT_CYC_DEF = 1048576;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_DELAY     = 3'd2,
    ST_WINDOW    = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // A sync edge arriving while a shot is already being serviced is dropped.
  function automatic logic is_busy_shot(input state_e st);
    return (st == ST_DELAY) || (st == ST_WINDOW) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/syn_md_rise_sync.sv
// -----------------------------------------------------------------------------
// syn_md_rise_sync
// Two-flop synchroniser for the raw tool sync marker plus a history flop used
// to detect a rising edge in the clkin domain.
// Ports:
//   clkin   - system clock (rising edge)
//   rst_n   - asynchronous active-low reset, clears all three flops
//   async_i - raw asynchronous sync marker
//   rise_o  - combinational one-cycle rise indication (s2 & ~s3)
// -----------------------------------------------------------------------------
module syn_md_rise_sync (
  input  logic clkin,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchroniser chain and edge-history flop.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/syn_md_acq_sched.sv
// -----------------------------------------------------------------------------
// syn_md_acq_sched
// Acquisition scheduler: after an arm request, waits for a synchronised rise
// of the tool sync marker, counts a programmable delay, then opens an
// acquisition window of programmable length. Repeats for a programmable
// number of shots and signals completion.
//
// Optional feature: define SYN_MD_TIMEOUT_EN to build a sync-wait timeout of
// TIMEOUT_CYC cycles; otherwise WAIT_SYNC waits forever and timeout is 0.
//
// Ports:
//   clkin, rst_n        - clock (rising edge) / async active-low reset
//   syn_md_temp         - raw asynchronous sync marker
//   arm                 - level-sampled start request (honoured in IDLE only)
//   abort               - synchronous cancel, highest priority
//   dly_cfg, win_cfg    - delay and window length in cycles (latched at arm)
//   shots_cfg           - shots per sequence (latched at arm)
//   acq_en, acq_start   - window enable / first-window-cycle pulse
//   acq_done            - sequence-end pulse
//   busy                - high whenever not IDLE
//   shot_cnt            - shots completed in the current sequence
//   missed_sync         - pulse when a sync rise is ignored
//   timeout             - pulse when the sync wait expires
// -----------------------------------------------------------------------------
module syn_md_acq_sched
  import syn_md_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SHOT_W      = SHOT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              syn_md_temp,
  input  logic              arm,
  input  logic              abort,
  input  logic [CNT_W-1:0]  dly_cfg,
  input  logic [CNT_W-1:0]  win_cfg,
  input  logic [SHOT_W-1:0] shots_cfg,
  output logic              acq_en,
  output logic              acq_start,
  output logic              acq_done,
  output logic              busy,
  output logic [SHOT_W-1:0] shot_cnt,
  output logic              missed_sync,
  output logic              timeout
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  dly_q, dly_d;
  logic [CNT_W-1:0]  win_q, win_d;
  logic [SHOT_W-1:0] shots_q, shots_d;
  logic [CNT_W-1:0]  dly_cnt_q, dly_cnt_d;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic [SHOT_W-1:0] shot_cnt_q, shot_cnt_d;
  logic              missed_d;
  logic              acq_en_q, acq_start_q, acq_done_q, busy_q, missed_q;
  logic              rise_s;

  syn_md_rise_sync u_rise_sync (
    .clkin   (clkin),
    .rst_n   (rst_n),
    .async_i (syn_md_temp),
    .rise_o  (rise_s)
  );

`ifdef SYN_MD_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_hit_s;
  logic             timeout_d;
  logic             timeout_q;

  assign tmo_hit_s = (tmo_cnt_q == TMO_LAST);

  // Dwell counter: restarts on every WAIT_SYNC entry, counts while staying.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q == ST_WAIT_SYNC) && (state_d == ST_WAIT_SYNC)) begin
        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      end else begin
        tmo_cnt_q <= '0;
      end
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Next-state, counter and latched-config logic; abort overrides everything.
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    win_d      = win_q;
    shots_d    = shots_q;
    dly_cnt_d  = dly_cnt_q;
    win_cnt_d  = win_cnt_q;
    shot_cnt_d = shot_cnt_q;
    missed_d   = 1'b0;
`ifdef SYN_MD_TIMEOUT_EN
    timeout_d  = 1'b0;
`endif
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      // Ignored rises in the shot-servicing states are reported, not queued.
      missed_d = rise_s & is_busy_shot(state_q);
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            dly_d      = dly_cfg;
            win_d      = (win_cfg == '0) ? CNT_W'(1) : win_cfg;
            shots_d    = (shots_cfg == '0) ? SHOT_W'(1) : shots_cfg;
            shot_cnt_d = '0;
            state_d    = ST_WAIT_SYNC;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_SYNC: begin
          if (rise_s) begin
            if (dly_q == '0) begin
              win_cnt_d = win_q;
              state_d   = ST_WINDOW;
            end else begin
              dly_cnt_d = dly_q;
              state_d   = ST_DELAY;
            end
`ifdef SYN_MD_TIMEOUT_EN
          end else if (tmo_hit_s) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
`endif
          end else begin
            state_d = ST_WAIT_SYNC;
          end
        end
        ST_DELAY: begin
          // Counter was loaded with D on entry, so D cycles elapse in DELAY.
          if (dly_cnt_q == CNT_W'(1)) begin
            win_cnt_d = win_q;
            state_d   = ST_WINDOW;
          end else begin
            dly_cnt_d = dly_cnt_q - CNT_W'(1);
          end
        end
        ST_WINDOW: begin
          if (win_cnt_q == CNT_W'(1)) begin
            shot_cnt_d = shot_cnt_q + SHOT_W'(1);
            state_d    = (shot_cnt_d == shots_q) ? ST_DONE : ST_WAIT_SYNC;
          end else begin
            win_cnt_d = win_cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, latched configuration and counters.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dly_q      <= '0;
      win_q      <= '0;
      shots_q    <= '0;
      dly_cnt_q  <= '0;
      win_cnt_q  <= '0;
      shot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      win_q      <= win_d;
      shots_q    <= shots_d;
      dly_cnt_q  <= dly_cnt_d;
      win_cnt_q  <= win_cnt_d;
      shot_cnt_q <= shot_cnt_d;
    end
  end

  // Outputs registered from the next state so they align with the state flop.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      acq_en_q    <= 1'b0;
      acq_start_q <= 1'b0;
      acq_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      acq_en_q    <= (state_d == ST_WINDOW);
      acq_start_q <= (state_d == ST_WINDOW) && (state_q != ST_WINDOW);
      acq_done_q  <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
      missed_q    <= missed_d;
    end
  end

  assign acq_en      = acq_en_q;
  assign acq_start   = acq_start_q;
  assign acq_done    = acq_done_q;
  assign busy        = busy_q;
  assign shot_cnt    = shot_cnt_q;
  assign missed_sync = missed_q;

endmodule

// File: tb/tb_syn_md_acq_sched.sv
// -----------------------------------------------------------------------------
// tb_syn_md_acq_sched
// Directed bench for syn_md_acq_sched. Cycle k of a recorded sequence is the
// sample taken 1 time unit after edge E_k; pin/arm/abort schedules give the
// input level present at edge E_k.
// -----------------------------------------------------------------------------
module tb_syn_md_acq_sched;

  logic        clkin = 1'b0;
  logic        rst_n = 1'b0;
  logic        syn_md_temp = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] dly_cfg = 16'd0;
  logic [15:0] win_cfg = 16'd0;
  logic [7:0]  shots_cfg = 8'd0;
  logic        acq_en, acq_start, acq_done, busy, missed_sync, timeout;
  logic [7:0]  shot_cnt;

  int total = 0;
  int bad   = 0;

  logic [63:0] pin_s, arm_s, abt_s;
  logic [63:0] rec_en, rec_st, rec_dn, rec_busy, rec_ms, rec_to;
  logic [7:0]  rec_shot [64];

  syn_md_acq_sched #(
    .CNT_W       (16),
    .SHOT_W      (8),
    .TIMEOUT_CYC (100)
  ) dut (
    .clkin       (clkin),
    .rst_n       (rst_n),
    .syn_md_temp (syn_md_temp),
    .arm         (arm),
    .abort       (abort),
    .dly_cfg     (dly_cfg),
    .win_cfg     (win_cfg),
    .shots_cfg   (shots_cfg),
    .acq_en      (acq_en),
    .acq_start   (acq_start),
    .acq_done    (acq_done),
    .busy        (busy),
    .shot_cnt    (shot_cnt),
    .missed_sync (missed_sync),
    .timeout     (timeout)
  );

  always #5 clkin = ~clkin;

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic do_arm(input logic [15:0] d, input logic [15:0] w, input logic [7:0] s);
    dly_cfg   = d;
    win_cfg   = w;
    shots_cfg = s;
    arm       = 1'b1;
    tick();
    arm = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      $display("FAIL arm_busy: got %b want 1", busy);
      bad++;
    end
  endtask

  task automatic run_seq(input int n);
    rec_en = '0; rec_st = '0; rec_dn = '0; rec_busy = '0; rec_ms = '0; rec_to = '0;
    syn_md_temp = pin_s[0];
    arm         = arm_s[0];
    abort       = abt_s[0];
    for (int k = 0; k < n; k++) begin
      @(posedge clkin);
      #1;
      rec_en[k]   = acq_en;
      rec_st[k]   = acq_start;
      rec_dn[k]   = acq_done;
      rec_busy[k] = busy;
      rec_ms[k]   = missed_sync;
      rec_to[k]   = timeout;
      rec_shot[k] = shot_cnt;
      syn_md_temp = pin_s[k+1];
      arm         = arm_s[k+1];
      abort       = abt_s[k+1];
    end
    syn_md_temp = 1'b0;
    arm         = 1'b0;
    abort       = 1'b0;
  endtask

  task automatic chk_vec(input string nm, input logic [63:0] got, input logic [63:0] want);
    // thin formatter kept local to each caller's inline compare below
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    total++;
    if ({acq_en, acq_start, acq_done, busy, missed_sync, timeout, shot_cnt} !== 14'd0) begin
      $display("FAIL reset_outputs: got %b want 0", {acq_en, acq_start, acq_done, busy, missed_sync, timeout, shot_cnt});
      bad++;
    end
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if ({busy, acq_en, shot_cnt} !== 10'd0) begin
      $display("FAIL reset_idle: got %b want 0", {busy, acq_en, shot_cnt});
      bad++;
    end
  endtask

  // dly=3 win=5 shots=1; arm toggled and config changed while busy.
  task automatic test_single_shot();
    do_arm(16'd3, 16'd5, 8'd1);
    dly_cfg = 16'd0; win_cfg = 16'd1; shots_cfg = 8'd3;
    pin_s = 64'h3; arm_s = 64'h78; abt_s = 64'h0;
    run_seq(14);
    total++;
    if (rec_en !== 64'h3E0) begin $display("FAIL single_en: got %h want %h", rec_en, 64'h3E0); bad++; end
    total++;
    if (rec_st !== 64'h20) begin $display("FAIL single_start: got %h want %h", rec_st, 64'h20); bad++; end
    total++;
    if (rec_dn !== 64'h400) begin $display("FAIL single_done: got %h want %h", rec_dn, 64'h400); bad++; end
    total++;
    if (rec_busy !== 64'h7FF) begin $display("FAIL single_busy: got %h want %h", rec_busy, 64'h7FF); bad++; end
    total++;
    if ((rec_ms | rec_to) !== 64'h0) begin $display("FAIL single_ms_to: got %h want 0", rec_ms | rec_to); bad++; end
    total++;
    if (rec_shot[13] !== 8'd1) begin $display("FAIL single_shot_cnt: got %0d want 1", rec_shot[13]); bad++; end
  endtask

  // dly=0 win=0 shots=2, sync edges 20 cycles apart.
  task automatic test_zero_cfg_two_shots();
    do_arm(16'd0, 16'd0, 8'd2);
    pin_s = 64'h300003; arm_s = 64'h0; abt_s = 64'h0;
    run_seq(28);
    total++;
    if (rec_en !== 64'h400004) begin $display("FAIL two_en: got %h want %h", rec_en, 64'h400004); bad++; end
    total++;
    if (rec_st !== 64'h400004) begin $display("FAIL two_start: got %h want %h", rec_st, 64'h400004); bad++; end
    total++;
    if (rec_dn !== 64'h800000) begin $display("FAIL two_done: got %h want %h", rec_dn, 64'h800000); bad++; end
    total++;
    if (rec_busy !== 64'hFFFFFF) begin $display("FAIL two_busy: got %h want %h", rec_busy, 64'hFFFFFF); bad++; end
    total++;
    if ({rec_shot[2], rec_shot[3], rec_shot[22], rec_shot[23], rec_shot[27]} !== {8'd0, 8'd1, 8'd1, 8'd2, 8'd2}) begin
      $display("FAIL two_shot_cnt: got %0d %0d %0d %0d %0d want 0 1 1 2 2",
               rec_shot[2], rec_shot[3], rec_shot[22], rec_shot[23], rec_shot[27]);
      bad++;
    end
  endtask

  // dly=10 win=4, second sync edge arrives during DELAY.
  task automatic test_missed_sync();
    do_arm(16'd10, 16'd4, 8'd1);
    pin_s = 64'h63; arm_s = 64'h0; abt_s = 64'h0;
    run_seq(20);
    total++;
    if (rec_ms !== 64'h80) begin $display("FAIL missed_pulse: got %h want %h", rec_ms, 64'h80); bad++; end
    total++;
    if (rec_en !== 64'hF000) begin $display("FAIL missed_en: got %h want %h", rec_en, 64'hF000); bad++; end
    total++;
    if (rec_st !== 64'h1000) begin $display("FAIL missed_start: got %h want %h", rec_st, 64'h1000); bad++; end
    total++;
    if ((rec_dn !== 64'h10000) || (rec_busy !== 64'h1FFFF)) begin
      $display("FAIL missed_done_busy: got %h/%h want %h/%h", rec_dn, rec_busy, 64'h10000, 64'h1FFFF);
      bad++;
    end
  endtask

  task automatic test_abort();
    // abort coincident with the rise in WAIT_SYNC
    do_arm(16'd2, 16'd3, 8'd1);
    pin_s = 64'h3; arm_s = 64'h0; abt_s = 64'h4;
    run_seq(8);
    total++;
    if (rec_busy !== 64'h3) begin $display("FAIL abort_rise_busy: got %h want %h", rec_busy, 64'h3); bad++; end
    total++;
    if ((rec_en | rec_dn | rec_ms) !== 64'h0) begin $display("FAIL abort_rise_outs: got %h want 0", rec_en | rec_dn | rec_ms); bad++; end
    // abort in the second window of a two-shot sequence; shot count held at 1
    do_arm(16'd2, 16'd3, 8'd2);
    pin_s = 64'hC03; arm_s = 64'h0; abt_s = 64'h8000;
    run_seq(20);
    total++;
    if (rec_en !== 64'h4070) begin $display("FAIL abort_win_en: got %h want %h", rec_en, 64'h4070); bad++; end
    total++;
    if ((rec_dn !== 64'h0) || (rec_busy !== 64'h7FFF)) begin
      $display("FAIL abort_win_done_busy: got %h/%h want 0/%h", rec_dn, rec_busy, 64'h7FFF);
      bad++;
    end
    total++;
    if (rec_shot[19] !== 8'd1) begin $display("FAIL abort_win_shot: got %0d want 1", rec_shot[19]); bad++; end
  endtask

  // rst_n asserted mid-window drops everything without a clock edge.
  task automatic test_reset_mid_window();
    do_arm(16'd1, 16'd8, 8'd1);
    pin_s = 64'h3; arm_s = 64'h0; abt_s = 64'h0;
    run_seq(6);
    total++;
    if (rec_en[5] !== 1'b1) begin $display("FAIL rstwin_pre_en: got %b want 1", rec_en[5]); bad++; end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({acq_en, acq_start, acq_done, busy, missed_sync, timeout, shot_cnt} !== 14'd0) begin
      $display("FAIL rstwin_async: got %b want 0", {acq_en, acq_start, acq_done, busy, missed_sync, timeout, shot_cnt});
      bad++;
    end
    #3;
    rst_n = 1'b1;
    pin_s = 64'h0;
    run_seq(6);
    total++;
    if ((rec_dn | rec_en | rec_busy) !== 64'h0) begin
      $display("FAIL rstwin_after: got %h want 0", rec_dn | rec_en | rec_busy);
      bad++;
    end
  endtask

  task automatic test_timeout();
    do_arm(16'd1, 16'd1, 8'd1);
`ifdef SYN_MD_TIMEOUT_EN
    for (int i = 0; i < 99; i++) tick();
    total++;
    if ({busy, timeout} !== 2'b10) begin $display("FAIL tmo_before: got %b want 10", {busy, timeout}); bad++; end
    tick();
    total++;
    if ({busy, timeout} !== 2'b01) begin $display("FAIL tmo_pulse: got %b want 01", {busy, timeout}); bad++; end
    tick();
    total++;
    if ({busy, timeout} !== 2'b00) begin $display("FAIL tmo_after: got %b want 00", {busy, timeout}); bad++; end
`else
    for (int i = 0; i < 150; i++) tick();
    total++;
    if ({busy, timeout} !== 2'b10) begin $display("FAIL notmo_wait: got %b want 10", {busy, timeout}); bad++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({busy, timeout} !== 2'b00) begin $display("FAIL notmo_abort: got %b want 00", {busy, timeout}); bad++; end
`endif
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_zero_cfg_two_shots();
    test_missed_sync();
    test_abort();
    test_reset_mid_window();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
